// File: rtl/fetch_queue_stage_pkg.sv
// Shared types and defaults for the fetch stage and its fetch queue.
package fetch_queue_stage_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_INSN_WIDTH = 32;
    localparam int unsigned PC_STEP_DEFAULT = 4;
    localparam logic [DEF_ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction bit that marks a control-transfer opcode for predecode.
    localparam int unsigned BRANCH_BIT = 6;

    typedef logic [DEF_ADDR_WIDTH-1:0] pc_t;
    typedef logic [DEF_INSN_WIDTH-1:0] insn_t;

    // One fetch queue entry at the default widths.
    typedef struct packed {
        pc_t   pc;
        insn_t insn;
        logic  is_branch;
        logic  pred_taken;
        pc_t   pred_target;
    } fetch_queue_entry_t;

    // Predecode: branch class is flagged by a single opcode bit.
    function automatic logic predecode_is_branch(input logic [BRANCH_BIT:0] insn_low);
        return insn_low[BRANCH_BIT];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Generic circular FIFO with flush. Head entry is read from the storage
// register at the read pointer, so it is stable while not popped.
module fetch_queue
    import fetch_queue_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       head_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty_s;
    logic full_s;
    logic push_ok_s;
    logic pop_ok_s;

    // Accept a push when there is room or when a pop frees a slot in the same cycle.
    always_comb begin
        empty_s   = (count_q == {CNT_W{1'b0}});
        full_s    = (count_q == CNT_W'(DEPTH));
        pop_ok_s  = pop && !flush && !empty_s;
        push_ok_s = push && !flush && (!full_s || pop_ok_s);
    end

    // Next-state for storage, pointers and count; flush empties the queue.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers; storage is cleared on reset so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = (count_q != {CNT_W{1'b0}});
    assign count      = count_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: PC generation with BTB/direction prediction, single-entry
// in-flight tracking for a 1-cycle I-memory, epoch-based stale response
// dropping, and a credit-controlled fetch queue towards decode.
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned INSN_WIDTH = DEF_INSN_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_PC_DEFAULT),
    parameter int unsigned PC_STEP    = PC_STEP_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [ADDR_WIDTH-1:0]      redirect_pc,
    output logic                       imem_req_valid,
    output logic [ADDR_WIDTH-1:0]      imem_req_pc,
    input  logic                       imem_resp_valid,
    input  logic [INSN_WIDTH-1:0]      imem_resp_insn,
    input  logic                       btb_hit,
    input  logic [ADDR_WIDTH-1:0]      btb_target,
    input  logic                       bp_taken,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_WIDTH-1:0]      out_pc,
    output logic [INSN_WIDTH-1:0]      out_insn,
    output logic                       out_is_branch,
    output logic                       out_pred_taken,
    output logic [ADDR_WIDTH-1:0]      out_pred_target,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INSN_WIDTH-1:0] insn;
        logic                  is_branch;
        logic                  pred_taken;
        logic [ADDR_WIDTH-1:0] pred_target;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  epoch_q, epoch_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
    logic                  if_taken_q, if_taken_d;
    logic [ADDR_WIDTH-1:0] if_target_q, if_target_d;
    logic                  if_epoch_q, if_epoch_d;

    logic [CNT_W-1:0]      count_s;
    logic [CNT_W:0]        credit_used_s;
    logic                  issue_s;
    logic                  pred_taken_s;
    logic [ADDR_WIDTH-1:0] seq_pc_s;
    logic [ADDR_WIDTH-1:0] pred_target_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  head_valid_s;
    entry_t                push_entry_s;
    entry_t                head_entry_s;
    logic [ENTRY_W-1:0]    head_bits_s;

    // Issue decision and prediction. Queue entries plus the in-flight slot
    // form the credit pool, so a response always finds space.
    always_comb begin
        credit_used_s = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_q};
        issue_s       = !rst && !flush && (credit_used_s < (CNT_W+1)'(DEPTH));
        pred_taken_s  = btb_hit && bp_taken;
        seq_pc_s      = pc_q + ADDR_WIDTH'(PC_STEP);
        if (pred_taken_s) begin
            pred_target_s = btb_target;
        end else begin
            pred_target_s = seq_pc_s;
        end
    end

    // Response acceptance: only a response tagged with the current epoch is
    // queued; anything older belongs to a flushed path.
    always_comb begin
        push_s                   = imem_resp_valid && inflight_q && (if_epoch_q == epoch_q) && !flush;
        pop_s                    = head_valid_s && out_ready && !flush;
        push_entry_s.pc          = if_pc_q;
        push_entry_s.insn        = imem_resp_insn;
        push_entry_s.is_branch   = predecode_is_branch(imem_resp_insn[BRANCH_BIT:0]);
        push_entry_s.pred_taken  = if_taken_q;
        push_entry_s.pred_target = if_target_q;
    end

    // Next PC, epoch and in-flight tracking; flush outranks issue.
    always_comb begin
        pc_d        = pc_q;
        epoch_d     = epoch_q;
        inflight_d  = inflight_q;
        if_pc_d     = if_pc_q;
        if_taken_d  = if_taken_q;
        if_target_d = if_target_q;
        if_epoch_d  = if_epoch_q;
        if (flush) begin
            pc_d    = redirect_pc;
            epoch_d = ~epoch_q;
        end else if (issue_s) begin
            pc_d = pred_target_s;
        end else begin
            pc_d = pc_q;
        end
        if (issue_s) begin
            inflight_d  = 1'b1;
            if_pc_d     = pc_q;
            if_taken_d  = pred_taken_s;
            if_target_d = pred_target_s;
            if_epoch_d  = epoch_q;
        end else if (imem_resp_valid) begin
            inflight_d = 1'b0;
        end else begin
            inflight_d = inflight_q;
        end
    end

    // PC, epoch and in-flight registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            epoch_q     <= 1'b0;
            inflight_q  <= 1'b0;
            if_pc_q     <= {ADDR_WIDTH{1'b0}};
            if_taken_q  <= 1'b0;
            if_target_q <= {ADDR_WIDTH{1'b0}};
            if_epoch_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            epoch_q     <= epoch_d;
            inflight_q  <= inflight_d;
            if_pc_q     <= if_pc_d;
            if_taken_q  <= if_taken_d;
            if_target_q <= if_target_d;
            if_epoch_q  <= if_epoch_d;
        end
    end

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push_s),
        .push_data  (push_entry_s),
        .pop        (pop_s),
        .head_data  (head_bits_s),
        .head_valid (head_valid_s),
        .count      (count_s)
    );

    assign head_entry_s    = entry_t'(head_bits_s);
    assign imem_req_valid  = issue_s;
    assign imem_req_pc     = pc_q;
    assign out_valid       = head_valid_s;
    assign out_pc          = head_entry_s.pc;
    assign out_insn        = head_entry_s.insn;
    assign out_is_branch   = head_entry_s.is_branch;
    assign out_pred_taken  = head_entry_s.pred_taken;
    assign out_pred_target = head_entry_s.pred_target;
    assign occupancy       = count_s;

endmodule
